alu_control_seq: RTL
====================

// Module: alu_control_seq
// PURPOSE
//   EX-stage ALU control with multi-cycle op sequencing. Combinationally decodes
//   i_alu_op/i_funct into an ALU control code, as the single-cycle decoder did.
//   Adds MULT/MULTU/DIV/DIVU decode and a sequencer that drives the iterative
//   mult/div datapath, stalls the pipeline and writes HI/LO.
//   Adds MFHI/MFLO/MTHI/MTLO decode.
// PARAMETERS
//   ALU_CTR_BUS_WIDTH    4   width of ALU control code
//   ALU_OP_BUS_WIDTH     3   width of main-decoder ALU op class
//   ALU_FUNCT_BUS_WIDTH  6   width of R-type funct field
//   MULT_CYCLES          32  iterative step cycles for MULT/MULTU (>=1)
//   DIV_CYCLES           32  iterative step cycles for DIV/DIVU (>=1)
//   CNT_WIDTH            6   step counter width; >= clog2(max(MULT_CYCLES,DIV_CYCLES)+1)
// PORTS
//   i_clk           in   1    clock, rising edge
//   i_reset         in   1    asynchronous reset, active-high
//   i_valid         in   1    valid instruction present in EX
//   i_flush         in   1    squash EX instruction / abort sequence
//   i_funct         in   ALU_FUNCT_BUS_WIDTH  R-type funct
//   i_alu_op        in   ALU_OP_BUS_WIDTH     op class from main decoder
//   i_divisor_zero  in   1    rt operand == 0, sampled on DIV/DIVU accept
//   o_alu_ctr       out  ALU_CTR_BUS_WIDTH    ALU operation code
//   o_stall         out  1    hold IF/ID/EX; low = pipeline may advance
//   o_md_start      out  1    1-cycle pulse: datapath loads operands
//   o_md_step       out  1    datapath performs one iteration
//   o_md_is_div     out  1    latched: 1 = divide, 0 = multiply
//   o_md_signed     out  1    latched: 1 = MULT/DIV, 0 = MULTU/DIVU
//   o_hilo_we       out  1    1-cycle pulse: write HI and LO from datapath
//   o_hi_we         out  1    MTHI write enable (comb, gated by i_valid)
//   o_lo_we         out  1    MTLO write enable (comb, gated by i_valid)
//   o_hilo_rd_sel   out  2    00 none, 01 HI (MFHI), 10 LO (MFLO)
//   o_div_by_zero   out  1    1-cycle pulse: DIV/DIVU aborted on zero divisor
// BEHAVIOUR
//   o_alu_ctr: combinational. Full single-cycle table is retained (R-type funct
//     map; LOAD/STORE/ADDI->ADD, ANDI/ORI/XORI/SLTI, JUMP->SC_B, default NOP).
//     MULT*/DIV*/MTHI/MTLO -> NOP. MFHI/MFLO -> SC_B (HI/LO value on B path).
//   FSM states: IDLE, BUSY, DONE. Reset -> IDLE, counter 0, all registered outputs 0.
//   IDLE: if i_valid & R-type & funct in MULT*/DIV* & !i_flush:
//     o_stall=1 and o_md_start=1 (comb) this cycle; latch is_div/signed.
//     If DIV* & i_divisor_zero: go DONE with zero flag set.
//     Else: cnt <= N-1, where N = MULT_CYCLES or DIV_CYCLES; go BUSY.
//   BUSY: o_stall=1, o_md_step=1; cnt decrements each cycle; at cnt==0 -> DONE.
//     Exactly N step cycles.
//   DONE: o_stall=0. If zero flag: o_div_by_zero=1, o_hilo_we=0.
//     Otherwise: o_hilo_we=1. Always -> IDLE.
//     No restart in DONE, even though the same instruction is still valid.
//   Latency: accept at T; steps T+1..T+N; hilo_we at T+N+1.
//     o_stall is high N+1 cycles.
//   i_flush: highest priority. Blocks accept in IDLE. In BUSY/DONE it forces
//     IDLE next cycle and suppresses o_hilo_we/o_div_by_zero in that cycle.
//     o_stall drops in the flush cycle.
//   Hazard: MFHI/MFLO/MTHI/MTLO arriving while BUSY are held by o_stall.
//     o_hi_we/o_lo_we/o_hilo_rd_sel = 0 unless state IDLE/DONE & i_valid.
//   Reset mid-operation: async return to IDLE; all outputs 0 immediately;
//     no HI/LO write.
//   o_md_is_div/o_md_signed hold their latched value until the next accept.
// STRUCTURE
//   Shared header alu_control.vh gains:
//     CODE_FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO (0x18,0x19,0x1A,0x1B,0x10,0x12,0x11,0x13);
//     FSM state codes; HILO_RD_SEL codes.
//   Sub-module alu_md_sequencer: FSM + counter + pulses.
//   Top-level alu_control_seq: decode table + gating.
// TESTING
//   1 R-type ADD, SLT, default funct 0x3F; LOAD, ORI ->
//     o_alu_ctr = ADD, SLT, NOP; ADD, OR; o_stall=0 throughout.
//   2 MULT, MULT_CYCLES=32, held valid -> start at T, 32 step cycles,
//     hilo_we at T+33, signed=1, stall high 33 cycles; no second start.
//   3 DIVU, i_divisor_zero=1 -> 1 stall cycle, then div_by_zero pulse,
//     hilo_we=0, is_div=1 signed=0.
//   4 DIV with flush asserted at step 10 -> IDLE next cycle, no hilo_we,
//     stall low in flush cycle; next MULTU accepted normally.
//   5 i_reset pulsed mid-BUSY (async, off clock edge) -> outputs 0 at once,
//     FSM IDLE, no hilo_we.
//   6 MFLO issued during BUSY -> hilo_rd_sel=00 while BUSY; 10 in DONE cycle.
//     MTHI in IDLE -> o_hi_we=1, o_alu_ctr=NOP.

Source files
------------

// File: rtl/alu_control_seq_pkg.sv
// Shared constants and types for the EX-stage ALU control and mult/div sequencer.
package alu_control_seq_pkg;

  localparam int unsigned ALU_CTR_W   = 4;
  localparam int unsigned ALU_OP_W    = 3;
  localparam int unsigned ALU_FUNCT_W = 6;

  localparam logic [ALU_CTR_W-1:0] CTR_AND  = 4'h0;
  localparam logic [ALU_CTR_W-1:0] CTR_OR   = 4'h1;
  localparam logic [ALU_CTR_W-1:0] CTR_ADD  = 4'h2;
  localparam logic [ALU_CTR_W-1:0] CTR_XOR  = 4'h3;
  localparam logic [ALU_CTR_W-1:0] CTR_SLL  = 4'h4;
  localparam logic [ALU_CTR_W-1:0] CTR_SRL  = 4'h5;
  localparam logic [ALU_CTR_W-1:0] CTR_SUB  = 4'h6;
  localparam logic [ALU_CTR_W-1:0] CTR_SLT  = 4'h7;
  localparam logic [ALU_CTR_W-1:0] CTR_SRA  = 4'h8;
  localparam logic [ALU_CTR_W-1:0] CTR_SC_B = 4'h9;
  localparam logic [ALU_CTR_W-1:0] CTR_SLTU = 4'hA;
  localparam logic [ALU_CTR_W-1:0] CTR_NOR  = 4'hC;
  localparam logic [ALU_CTR_W-1:0] CTR_NOP  = 4'hF;

  // Op classes from the main decoder; LOAD and STORE share the memory class
  localparam logic [ALU_OP_W-1:0] ALU_OP_MEM   = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDI  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ANDI  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ORI   = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XORI  = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTI  = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_JUMP  = 3'd7;

  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_AND   = 6'h24;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_OR    = 6'h25;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [ALU_FUNCT_W-1:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] HILO_RD_NONE = 2'b00;
  localparam logic [1:0] HILO_RD_HI   = 2'b01;
  localparam logic [1:0] HILO_RD_LO   = 2'b10;

  // Mult/div command captured on accept
  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic div_zero;
  } md_cmd_t;

  function automatic logic is_md_funct(input logic [ALU_FUNCT_W-1:0] f);
    return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// EX-stage bus between pipeline control and the ALU control / mult-div sequencer.
interface alu_control_seq_if
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned ALU_CTR_BUS_WIDTH   = ALU_CTR_W,
  parameter int unsigned ALU_OP_BUS_WIDTH    = ALU_OP_W,
  parameter int unsigned ALU_FUNCT_BUS_WIDTH = ALU_FUNCT_W
);
  logic                           i_valid;
  logic                           i_flush;
  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct;
  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op;
  logic                           i_divisor_zero;
  logic [ALU_CTR_BUS_WIDTH-1:0]   o_alu_ctr;
  logic                           o_stall;
  logic                           o_md_start;
  logic                           o_md_step;
  logic                           o_md_is_div;
  logic                           o_md_signed;
  logic                           o_hilo_we;
  logic                           o_hi_we;
  logic                           o_lo_we;
  logic [1:0]                     o_hilo_rd_sel;
  logic                           o_div_by_zero;

  modport master (
    output i_valid, i_flush, i_funct, i_alu_op, i_divisor_zero,
    input  o_alu_ctr, o_stall, o_md_start, o_md_step, o_md_is_div, o_md_signed,
           o_hilo_we, o_hi_we, o_lo_we, o_hilo_rd_sel, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_flush, i_funct, i_alu_op, i_divisor_zero,
    output o_alu_ctr, o_stall, o_md_start, o_md_step, o_md_is_div, o_md_signed,
           o_hilo_we, o_hi_we, o_lo_we, o_hilo_rd_sel, o_div_by_zero
  );
endinterface

// File: rtl/alu_control_seq_md_sequencer.sv
// Mult/div sequencer: accepts a command, runs N step cycles, then pulses the HI/LO write.
module alu_control_seq_md_sequencer
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_req,
  input  logic    i_flush,
  input  md_cmd_t i_cmd,
  output logic    o_stall,
  output logic    o_md_start,
  output logic    o_md_step,
  output logic    o_md_is_div,
  output logic    o_md_signed,
  output logic    o_hilo_we,
  output logic    o_div_by_zero,
  output logic    o_hilo_access_ok
);

  md_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   signed_q, signed_d;
  logic                   zero_q, zero_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      signed_q <= signed_d;
      zero_q   <= zero_d;
    end
  end

  // Flush aborts the sequence outright: no step, no stall, no write-back in that cycle
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    is_div_d         = is_div_q;
    signed_d         = signed_q;
    zero_d           = zero_q;
    o_stall          = 1'b0;
    o_md_start       = 1'b0;
    o_md_step        = 1'b0;
    o_hilo_we        = 1'b0;
    o_div_by_zero    = 1'b0;
    o_hilo_access_ok = 1'b0;
    case (state_q)
      MD_IDLE: begin
        o_hilo_access_ok = 1'b1;
        if (i_req && !i_flush) begin
          o_stall    = 1'b1;
          o_md_start = 1'b1;
          is_div_d   = i_cmd.is_div;
          signed_d   = i_cmd.is_signed;
          zero_d     = i_cmd.is_div && i_cmd.div_zero;
          if (i_cmd.is_div && i_cmd.div_zero) begin
            state_d = MD_DONE;
            cnt_d   = '0;
          end else begin
            state_d = MD_BUSY;
            cnt_d   = i_cmd.is_div ? CNT_WIDTH'(DIV_CYCLES - 1) : CNT_WIDTH'(MULT_CYCLES - 1);
          end
        end
      end
      MD_BUSY: begin
        if (i_flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          o_stall   = 1'b1;
          o_md_step = 1'b1;
          if (cnt_q == '0) begin
            state_d = MD_DONE;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      MD_DONE: begin
        // Always return to IDLE; the pipeline advances past the instruction this cycle
        o_hilo_access_ok = 1'b1;
        state_d          = MD_IDLE;
        zero_d           = 1'b0;
        if (!i_flush) begin
          o_hilo_we     = !zero_q;
          o_div_by_zero = zero_q;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign o_md_is_div = is_div_q;
  assign o_md_signed = signed_q;

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control: combinational op decode, HI/LO access gating and mult/div sequencing.
module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int unsigned ALU_CTR_BUS_WIDTH   = 4,
  parameter int unsigned ALU_OP_BUS_WIDTH    = 3,
  parameter int unsigned ALU_FUNCT_BUS_WIDTH = 6,
  parameter int unsigned MULT_CYCLES         = 32,
  parameter int unsigned DIV_CYCLES          = 32,
  parameter int unsigned CNT_WIDTH           = 6
) (
  input logic               i_clk,
  input logic               i_reset,
  alu_control_seq_if.slave  bus
);

  logic [ALU_FUNCT_BUS_WIDTH-1:0] funct_in;
  logic [ALU_OP_BUS_WIDTH-1:0]    alu_op_in;
  logic [ALU_FUNCT_W-1:0]         funct;
  logic [ALU_OP_W-1:0]            alu_op;
  logic [ALU_CTR_W-1:0]           alu_ctr_c;
  logic                           is_rtype;
  logic                           md_req;
  logic                           hilo_access_ok;
  logic                           hi_we_c;
  logic                           lo_we_c;
  logic [1:0]                     hilo_rd_sel_c;
  md_cmd_t                        md_cmd;

  assign funct_in  = bus.i_funct;
  assign alu_op_in = bus.i_alu_op;
  assign funct     = ALU_FUNCT_W'(funct_in);
  assign alu_op    = ALU_OP_W'(alu_op_in);
  assign is_rtype  = (alu_op == ALU_OP_RTYPE);

  always_comb begin
    alu_ctr_c = CTR_NOP;
    case (alu_op)
      ALU_OP_MEM, ALU_OP_ADDI: alu_ctr_c = CTR_ADD;
      ALU_OP_ANDI:             alu_ctr_c = CTR_AND;
      ALU_OP_ORI:              alu_ctr_c = CTR_OR;
      ALU_OP_XORI:             alu_ctr_c = CTR_XOR;
      ALU_OP_SLTI:             alu_ctr_c = CTR_SLT;
      ALU_OP_JUMP:             alu_ctr_c = CTR_SC_B;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alu_ctr_c = CTR_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctr_c = CTR_SUB;
          FUNCT_AND:             alu_ctr_c = CTR_AND;
          FUNCT_OR:              alu_ctr_c = CTR_OR;
          FUNCT_XOR:             alu_ctr_c = CTR_XOR;
          FUNCT_NOR:             alu_ctr_c = CTR_NOR;
          FUNCT_SLT:             alu_ctr_c = CTR_SLT;
          FUNCT_SLTU:            alu_ctr_c = CTR_SLTU;
          FUNCT_SLL:             alu_ctr_c = CTR_SLL;
          FUNCT_SRL:             alu_ctr_c = CTR_SRL;
          FUNCT_SRA:             alu_ctr_c = CTR_SRA;
          // HI/LO reads ride the B operand path
          FUNCT_MFHI, FUNCT_MFLO: alu_ctr_c = CTR_SC_B;
          default:               alu_ctr_c = CTR_NOP;
        endcase
      end
      default: alu_ctr_c = CTR_NOP;
    endcase
  end

  always_comb begin
    md_cmd.is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    md_cmd.is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    md_cmd.div_zero  = bus.i_divisor_zero;
  end

  // Reset also masks the request so nothing starts while reset is held
  assign md_req = !i_reset && bus.i_valid && is_rtype && is_md_funct(funct);

  // HI/LO moves are held off while a mult/div sequence owns HI/LO
  always_comb begin
    hi_we_c       = 1'b0;
    lo_we_c       = 1'b0;
    hilo_rd_sel_c = HILO_RD_NONE;
    if (!i_reset && hilo_access_ok && bus.i_valid && is_rtype) begin
      case (funct)
        FUNCT_MTHI: hi_we_c       = 1'b1;
        FUNCT_MTLO: lo_we_c       = 1'b1;
        FUNCT_MFHI: hilo_rd_sel_c = HILO_RD_HI;
        FUNCT_MFLO: hilo_rd_sel_c = HILO_RD_LO;
        default:    hilo_rd_sel_c = HILO_RD_NONE;
      endcase
    end
  end

  alu_control_seq_md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_md_seq (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_req            (md_req),
    .i_flush          (bus.i_flush),
    .i_cmd            (md_cmd),
    .o_stall          (bus.o_stall),
    .o_md_start       (bus.o_md_start),
    .o_md_step        (bus.o_md_step),
    .o_md_is_div      (bus.o_md_is_div),
    .o_md_signed      (bus.o_md_signed),
    .o_hilo_we        (bus.o_hilo_we),
    .o_div_by_zero    (bus.o_div_by_zero),
    .o_hilo_access_ok (hilo_access_ok)
  );

  assign bus.o_alu_ctr     = ALU_CTR_BUS_WIDTH'(alu_ctr_c);
  assign bus.o_hi_we       = hi_we_c;
  assign bus.o_lo_we       = lo_we_c;
  assign bus.o_hilo_rd_sel = hilo_rd_sel_c;

endmodule
